// File: rtl/alu_mac_pipe.sv
// rtl/alu_mac_pipe.sv - pipelined signed MUL/ADD/SUB/MAC unit with accumulator and optional saturation
`timescale 1ns/1ps
module alu_mac_pipe #(
    parameter int IN_W  = 19,
    parameter int OUT_W = 38,
    parameter int PIPE  = 2,
    parameter int SAT   = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    input  logic [1:0]              op_i,
    input  logic signed [IN_W-1:0]  a_i,
    input  logic signed [IN_W-1:0]  b_i,
    input  logic                    acc_clr_i,
    output logic                    out_valid_o,
    output logic signed [OUT_W-1:0] ans_o,
    output logic                    ovf_o
);
    localparam int PW = 2 * IN_W;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_ADD = 2'b01,
        OP_MAC = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    localparam logic signed [OUT_W-1:0] ACC_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] ACC_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    if (OUT_W < 2 * IN_W) begin : g_chk_width
        $error("alu_mac_pipe: OUT_W must be >= 2*IN_W");
    end
    if (PIPE < 1 || PIPE > 4) begin : g_chk_pipe
        $error("alu_mac_pipe: PIPE must be in 1..4");
    end

    logic                   in_valid_q;
    op_e                    in_op_q;
    logic                   in_clr_q;
    logic signed [IN_W-1:0] in_a_q;
    logic signed [IN_W-1:0] in_b_q;

    logic                   st_valid_q [PIPE];
    op_e                    st_op_q    [PIPE];
    logic                   st_clr_q   [PIPE];
    logic signed [PW-1:0]   st_val_q   [PIPE];

    logic signed [PW-1:0]   a_x;
    logic signed [PW-1:0]   b_x;
    logic signed [PW-1:0]   val_d;

    // Every op goes through the same stages so ADD/SUB stay ordered with MUL/MAC;
    // the extra stages beyond the first give the multiplier room to be retimed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_valid_q <= 1'b0;
            in_op_q    <= OP_MUL;
            in_clr_q   <= 1'b0;
            in_a_q     <= '0;
            in_b_q     <= '0;
            for (int i = 0; i < PIPE; i++) begin
                st_valid_q[i] <= 1'b0;
                st_op_q[i]    <= OP_MUL;
                st_clr_q[i]   <= 1'b0;
                st_val_q[i]   <= '0;
            end
        end else begin
            in_valid_q    <= in_valid_i;
            in_op_q       <= op_e'(op_i);
            in_clr_q      <= acc_clr_i;
            in_a_q        <= a_i;
            in_b_q        <= b_i;
            st_valid_q[0] <= in_valid_q;
            st_op_q[0]    <= in_op_q;
            st_clr_q[0]   <= in_clr_q;
            st_val_q[0]   <= val_d;
            for (int i = 1; i < PIPE; i++) begin
                st_valid_q[i] <= st_valid_q[i-1];
                st_op_q[i]    <= st_op_q[i-1];
                st_clr_q[i]   <= st_clr_q[i-1];
                st_val_q[i]   <= st_val_q[i-1];
            end
        end
    end

    always_comb begin
        a_x = PW'(in_a_q);
        b_x = PW'(in_b_q);
        case (in_op_q)
            OP_ADD:  val_d = a_x + b_x;
            OP_SUB:  val_d = a_x - b_x;
            default: val_d = a_x * b_x;
        endcase
    end

    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] ans_q, ans_d;
    logic                    ovf_q, ovf_d;
    logic signed [OUT_W-1:0] acc_q, acc_d;

    logic                    tap_valid;
    op_e                     tap_op;
    logic                    tap_clr;
    logic signed [OUT_W:0]   tap_x;
    logic signed [OUT_W:0]   acc_base;
    logic signed [OUT_W:0]   mac_sum;
    logic                    mac_ovf;
    logic signed [OUT_W-1:0] mac_res;

    // The accumulator lives here, so consecutive MACs see each other's result with no forwarding.
    always_comb begin
        tap_valid   = st_valid_q[PIPE-1];
        tap_op      = st_op_q[PIPE-1];
        tap_clr     = st_clr_q[PIPE-1];
        tap_x       = (OUT_W+1)'(st_val_q[PIPE-1]);
        acc_base    = tap_clr ? '0 : (OUT_W+1)'(acc_q);
        mac_sum     = acc_base + tap_x;
        mac_ovf     = mac_sum[OUT_W] ^ mac_sum[OUT_W-1];
        mac_res     = mac_sum[OUT_W-1:0];
        if (mac_ovf && SAT != 0) begin
            mac_res = mac_sum[OUT_W] ? ACC_MIN : ACC_MAX;
        end

        out_valid_d = tap_valid;
        ans_d       = ans_q;
        ovf_d       = 1'b0;
        acc_d       = acc_q;
        if (tap_valid && tap_op == OP_MAC) begin
            acc_d = mac_res;
            ans_d = mac_res;
            ovf_d = mac_ovf;
        end else begin
            if (tap_clr) begin
                acc_d = '0;
            end
            if (tap_valid) begin
                ans_d = tap_x[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            ans_q       <= '0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ans_q       <= ans_d;
            ovf_q       <= ovf_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign ans_o       = ans_q;
    assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_alu_mac_pipe.sv
// tb/tb_alu_mac_pipe.sv - self-checking bench for alu_mac_pipe across PIPE/SAT variants
`timescale 1ns/1ps
module tb_alu_mac_pipe;
    localparam int IW = 19;
    localparam int OW = 38;
    localparam int ND = 4;
    localparam int HN = 16384;
    localparam int NT = 23;
    localparam longint MAXV = (longint'(1) <<< (OW-1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (OW-1));
    localparam longint MODV = longint'(1) <<< OW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic [1:0]           op = 2'b00;
    logic signed [IW-1:0] a = '0;
    logic signed [IW-1:0] b = '0;
    logic                 acc_clr = 1'b0;
    logic                 d_valid [ND];
    logic signed [OW-1:0] d_ans   [ND];
    logic                 d_ovf   [ND];

    always #5 clk = ~clk;

    // dut0: PIPE2 SAT1, dut1: PIPE2 SAT0, dut2: PIPE1 SAT1, dut3: PIPE4 SAT0
    for (genvar k = 0; k < ND; k++) begin : g_dut
        alu_mac_pipe #(
            .IN_W (IW),
            .OUT_W(OW),
            .PIPE (k == 2 ? 1 : (k == 3 ? 4 : 2)),
            .SAT  (k % 2 == 0 ? 1 : 0)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .in_valid_i (in_valid),
            .op_i       (op),
            .a_i        (a),
            .b_i        (b),
            .acc_clr_i  (acc_clr),
            .out_valid_o(d_valid[k]),
            .ans_o      (d_ans[k]),
            .ovf_o      (d_ovf[k])
        );
    end

    function automatic int lat_of(int k);
        return (k == 2) ? 2 : ((k == 3) ? 5 : 3);
    endfunction

    typedef struct {
        bit     v;
        longint ans;
        bit     ovf;
    } res_t;

    typedef struct {
        bit       v;
        bit [1:0] op;
        longint   a;
        longint   b;
        bit       clr;
        longint   s_ans;
        bit       s_ovf;
        longint   w_ans;
        bit       w_ovf;
    } vec_t;

    res_t   hist   [2][HN];
    res_t   ex_res [2][HN];
    bit     ex_set [HN];
    longint acc_m  [2];
    longint last_m [2];
    vec_t   tbl    [NT];
    int     n;
    int     vectors;
    int     miscompares;

    // s=0 saturating accumulator, s=1 wrapping accumulator
    task automatic model_tok(input int s, input bit v, input bit [1:0] opc, input longint x,
                             input longint y, input bit clr, output res_t r);
        longint t;
        r.v   = v;
        r.ovf = 1'b0;
        if (v && opc == 2'b10) begin
            t = (clr ? 64'sd0 : acc_m[s]) + x * y;
            if (t > MAXV) begin
                r.ovf = 1'b1;
                t = (s == 0) ? MAXV : t - MODV;
            end else if (t < MINV) begin
                r.ovf = 1'b1;
                t = (s == 0) ? MINV : t + MODV;
            end
            acc_m[s]  = t;
            last_m[s] = t;
        end else begin
            if (clr) acc_m[s] = 0;
            if (v) last_m[s] = (opc == 2'b00) ? x * y : ((opc == 2'b01) ? x + y : x - y);
        end
        r.ans = last_m[s];
    endtask

    task automatic cmp(input string nm, input int k, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", nm, k, n, act, exp);
        end
    endtask

    task automatic check_all();
        res_t e;
        for (int k = 0; k < ND; k++) begin
            int idx = n - lat_of(k);
            e = '{v: 1'b0, ans: 64'sd0, ovf: 1'b0};
            if (idx >= 1) e = hist[k % 2][idx];
            cmp("out_valid", k, longint'(d_valid[k]), longint'(e.v));
            cmp("ans", k, longint'(d_ans[k]), e.ans);
            cmp("ovf", k, longint'(d_ovf[k]), longint'(e.ovf));
            if (k < 2 && idx >= 1 && ex_set[idx]) begin
                cmp("tbl_valid", k, longint'(d_valid[k]), longint'(ex_res[k][idx].v));
                cmp("tbl_ans", k, longint'(d_ans[k]), ex_res[k][idx].ans);
                cmp("tbl_ovf", k, longint'(d_ovf[k]), longint'(ex_res[k][idx].ovf));
            end
        end
    endtask

    task automatic tick(input bit v, input bit [1:0] opc, input longint x, input longint y, input bit clr);
        res_t r;
        @(negedge clk);
        check_all();
        if (n + 1 >= HN) begin
            $display("FAIL history overflow at cycle %0d", n);
            $fatal(1, "history overflow");
        end
        in_valid = v;
        op       = opc;
        a        = IW'(x);
        b        = IW'(y);
        acc_clr  = clr;
        for (int s = 0; s < 2; s++) begin
            model_tok(s, v, opc, x, y, clr, r);
            hist[s][n+1] = r;
        end
        ex_set[n+1] = 1'b0;
        @(posedge clk);
        n++;
    endtask

    task automatic model_clear();
        n = 0;
        for (int s = 0; s < 2; s++) begin
            acc_m[s]  = 0;
            last_m[s] = 0;
        end
        for (int i = 0; i < HN; i++) ex_set[i] = 1'b0;
    endtask

    // Called right after a tick returns, i.e. at a rising edge with tokens still in flight.
    task automatic do_reset();
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) begin
            cmp("rst_valid", k, longint'(d_valid[k]), 0);
            cmp("rst_ans", k, longint'(d_ans[k]), 0);
            cmp("rst_ovf", k, longint'(d_ovf[k]), 0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    initial begin
        longint x, y;
        bit     v, clr;
        bit [1:0] opc;
        vectors     = 0;
        miscompares = 0;

        tbl[0]  = '{1, 2'b00,       7,      -3, 0,                     -21, 0,                     -21, 0};
        tbl[1]  = '{1, 2'b01,       7,      -3, 0,                       4, 0,                       4, 0};
        tbl[2]  = '{1, 2'b11,       7,      -3, 0,                      10, 0,                      10, 0};
        tbl[3]  = '{0, 2'b10,       0,       0, 1,                      10, 0,                      10, 0};
        tbl[4]  = '{1, 2'b10,       2,       3, 1,                       6, 0,                       6, 0};
        tbl[5]  = '{1, 2'b10,       4,       5, 0,                      26, 0,                      26, 0};
        tbl[6]  = '{1, 2'b10,      -1,       6, 0,                      20, 0,                      20, 0};
        tbl[7]  = '{1, 2'b10,       1,       1, 1,                       1, 0,                       1, 0};
        tbl[8]  = '{1, 2'b10,       3,       3, 0,                      10, 0,                      10, 0};
        tbl[9]  = '{0, 2'b00,       0,       0, 0,                      10, 0,                      10, 0};
        tbl[10] = '{1, 2'b00,      -5,       4, 0,                     -20, 0,                     -20, 0};
        tbl[11] = '{1, 2'b10,       2,       2, 0,                      14, 0,                      14, 0};
        tbl[12] = '{1, 2'b11, -262144,  262143, 0,                 -524287, 0,                 -524287, 0};
        tbl[13] = '{1, 2'b01,  262143,  262143, 0,                  524286, 0,                  524286, 0};
        tbl[14] = '{1, 2'b10, -262144, -262144, 1,   64'sd68719476736,  0,   64'sd68719476736,  0};
        tbl[15] = '{1, 2'b10, -262144, -262144, 0,   64'sd137438953471, 1,  -64'sd137438953472, 1};
        tbl[16] = '{1, 2'b10, -262144, -262144, 0,   64'sd137438953471, 1,  -64'sd68719476736,  0};
        tbl[17] = '{1, 2'b10,       1,       1, 0,   64'sd137438953471, 1,  -64'sd68719476735,  0};
        tbl[18] = '{1, 2'b10,      -1,       1, 0,   64'sd137438953470, 0,  -64'sd68719476736,  0};
        tbl[19] = '{1, 2'b00, -262144, -262144, 0,   64'sd68719476736,  0,   64'sd68719476736,  0};
        tbl[20] = '{1, 2'b10,  262143, -262144, 1,  -64'sd68719214592,  0,  -64'sd68719214592,  0};
        tbl[21] = '{1, 2'b10,  262143, -262144, 0,  -64'sd137438429184, 0,  -64'sd137438429184, 0};
        tbl[22] = '{1, 2'b10,  262143, -262144, 0,  -64'sd137438953472, 1,   64'sd68720263168,  1};

        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < NT; i++) begin
            tick(tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].clr);
            ex_set[n]    = 1'b1;
            ex_res[0][n] = '{v: tbl[i].v, ans: tbl[i].s_ans, ovf: tbl[i].s_ovf};
            ex_res[1][n] = '{v: tbl[i].v, ans: tbl[i].w_ans, ovf: tbl[i].w_ovf};
        end
        repeat (3) tick(0, 2'b00, 0, 0, 0);

        tick(1, 2'b10, 100, 200, 0);
        tick(1, 2'b00, -7, 9, 0);
        tick(1, 2'b01, 33, -44, 0);
        do_reset();
        repeat (6) tick(0, 2'b00, 0, 0, 0);

        for (int i = 0; i < 10000; i++) begin
            v   = ($urandom_range(0, 9) != 0);
            opc = 2'($urandom_range(0, 3));
            clr = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 2) == 0) x = $urandom_range(0, 1) ? -262144 : 262143;
            else x = longint'($signed(IW'($urandom)));
            if ($urandom_range(0, 2) == 0) y = $urandom_range(0, 1) ? -262144 : 262143;
            else y = longint'($signed(IW'($urandom)));
            tick(v, opc, x, y, clr);
        end
        repeat (6) tick(0, 2'b00, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
